// File: rtl/periph_interco_pkg.sv
// Shared types and constants for the peripheral interconnect.
// Response bundle and protocol field widths.
package periph_interco_pkg;

  localparam int ATOP_WIDTH      = 6;
  localparam int MAX_OUTSTANDING = 4;
  localparam int RESP_DATA_W     = 32;
  localparam int RESP_ID_W       = 16;

  typedef struct packed {
    logic [RESP_DATA_W-1:0] rdata;
    logic                   opc;
    logic [RESP_ID_W-1:0]   id;
  } resp_t;

endpackage

// File: rtl/periph_id_fifo.sv
// In-order ID queue for outstanding requests.
// Head is read combinationally; an empty FIFO never falls through.
module periph_id_fifo
  import periph_interco_pkg::*;
#(
  parameter int ID_WIDTH = 16,
  parameter int DEPTH    = MAX_OUTSTANDING,
  parameter int PW       = $clog2(DEPTH),
  parameter int CW       = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_i,
  input  logic [ID_WIDTH-1:0] push_id_i,
  input  logic                pop_i,
  output logic [ID_WIDTH-1:0] head_id_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [CW-1:0]       count_o
);

  logic [ID_WIDTH-1:0] mem_q [DEPTH];
  logic [ID_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                do_push;
  logic                do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign head_id_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/periph_target_resp_adapter.sv
// Target-side request/response adapter for a peripheral port.
// Forwards requests, queues granted IDs, returns registered responses.
module periph_target_resp_adapter
  import periph_interco_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = RESP_ID_W,
  parameter int DATA_WIDTH      = RESP_DATA_W,
  parameter int BE_WIDTH        = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = periph_interco_pkg::MAX_OUTSTANDING
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_add_i,
  input  logic                  data_wen_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  input  logic [ATOP_WIDTH-1:0] data_atop_i,
  input  logic [ID_WIDTH-1:0]   data_ID_i,
  output logic                  data_gnt_o,
  output logic                  data_r_valid_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata_o,
  output logic                  data_r_opc_o,
  output logic [ID_WIDTH-1:0]   data_r_ID_o,
  output logic                  per_req_o,
  output logic [ADDR_WIDTH-1:0] per_add_o,
  output logic                  per_wen_o,
  output logic [DATA_WIDTH-1:0] per_wdata_o,
  output logic [BE_WIDTH-1:0]   per_be_o,
  output logic [ATOP_WIDTH-1:0] per_atop_o,
  input  logic                  per_gnt_i,
  input  logic                  per_r_valid_i,
  input  logic [DATA_WIDTH-1:0] per_r_rdata_i,
  input  logic                  per_r_opc_i,
  output logic                  idle_o,
  output logic                  resp_err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic                full;
  logic                empty;
  logic [CW-1:0]       count;
  logic [ID_WIDTH-1:0] head_id;
  logic                push;
  logic                pop;

  resp_t resp_q, resp_d;
  logic  valid_q, valid_d;
  logic  err_q, err_d;

  // Gating uses registered full, so a same-cycle pop cannot reopen it.
  assign per_req_o  = data_req_i & ~full;
  assign data_gnt_o = per_gnt_i & ~full;
  assign per_add_o   = data_add_i;
  assign per_wen_o   = data_wen_i;
  assign per_wdata_o = data_wdata_i;
  assign per_be_o    = data_be_i;
  assign per_atop_o  = data_atop_i;

  assign push = per_req_o & per_gnt_i;
  assign pop  = per_r_valid_i & ~empty;

  periph_id_fifo #(
    .ID_WIDTH (ID_WIDTH),
    .DEPTH    (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .push_id_i (data_ID_i),
    .pop_i     (pop),
    .head_id_o (head_id),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (count)
  );

  always_comb begin
    resp_d  = resp_q;
    valid_d = pop;
    err_d   = err_q | (per_r_valid_i & empty);
    if (pop) begin
      resp_d.rdata = per_r_rdata_i;
      resp_d.opc   = per_r_opc_i;
      resp_d.id    = head_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      resp_q  <= resp_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign data_r_valid_o = valid_q;
  assign data_r_rdata_o = resp_q.rdata;
  assign data_r_opc_o   = resp_q.opc;
  assign data_r_ID_o    = resp_q.id;
  assign idle_o         = (count == '0);
  assign resp_err_o     = err_q;

endmodule
